// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/subtract and iterative signed shift-add multiply.
// Latency: 1 cycle for add/sub/unsupported, WIDTH cycles for multiply; done pulses on completion.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy.
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [3:0]           command,
   input  logic [WIDTH-1:0]     inputA,
   input  logic [WIDTH-1:0]     inputB,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 error
);

   localparam logic [3:0] CMD_ADD = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0101;
   localparam logic [3:0] CMD_MUL = 4'b0010;
   // One guard bit above the product so the sign-bit subtraction never wraps.
   localparam int AW = 2*WIDTH + 1;
   localparam int CW = 6;

   typedef enum logic {S_IDLE, S_EXEC} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_finish;

   logic [CW-1:0]        r_cnt;
   logic [3:0]           r_cmd;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [AW-1:0]        r_acc;
   logic [AW-1:0]        r_bsh;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_error;

   logic                 w_mode;
   logic [WIDTH-1:0]     w_bx;
   logic [WIDTH-1:0]     w_sum;
   logic                 w_cout;
   logic                 w_cin_msb;
   logic                 w_ovf;
   logic [AW-1:0]        w_acc_nxt;
   logic                 w_mul_err;
   logic [2*WIDTH-1:0]   w_res_nxt;
   logic                 w_err_nxt;

   assign busy   = (r_state == S_EXEC);
   assign done   = r_done;
   assign result = r_result;
   assign error  = r_error;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: accept in IDLE, leave EXEC when the iteration counter hits its last count.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_cnt == CW'(1)) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Add/subtract datapath and overflow from carry into vs carry out of the MSB.
   always_comb begin
      w_mode            = (r_cmd == CMD_SUB);
      w_bx              = r_b ^ {WIDTH{w_mode}};
      {w_cout, w_sum}   = {1'b0, r_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_mode};
      w_cin_msb         = r_a[WIDTH-1] ^ w_bx[WIDTH-1] ^ w_sum[WIDTH-1];
      w_ovf             = w_cin_msb ^ w_cout;
   end

   // One multiply step: add the shifted B when the current A bit is set; the sign bit's weight is negative.
   always_comb begin
      w_acc_nxt = r_acc;
      if (r_a[0]) begin
         if (r_cnt == CW'(1)) w_acc_nxt = r_acc - r_bsh;
         else                 w_acc_nxt = r_acc + r_bsh;
      end
      // The exact product always fits in 2*WIDTH signed bits, so guard and sign bit agree.
      w_mul_err = w_acc_nxt[AW-1] ^ w_acc_nxt[AW-2];
   end

   // Completion value selected by the latched opcode.
   always_comb begin
      w_res_nxt = '0;
      w_err_nxt = 1'b1;
      case (r_cmd)
         CMD_ADD, CMD_SUB: begin
            w_res_nxt = {{WIDTH{w_sum[WIDTH-1]}}, w_sum};
            w_err_nxt = w_ovf;
         end
         CMD_MUL: begin
            w_res_nxt = w_acc_nxt[2*WIDTH-1:0];
            w_err_nxt = w_mul_err;
         end
         default: begin
            w_res_nxt = '0;
            w_err_nxt = 1'b1;
         end
      endcase
   end

   // Operand latch, iteration state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_cmd    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_bsh    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_error  <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_a   <= inputA;
            r_b   <= inputB;
            r_cmd <= command;
            r_acc <= '0;
            r_bsh <= {{(WIDTH+1){inputB[WIDTH-1]}}, inputB};
            r_cnt <= (command == CMD_MUL) ? CW'(WIDTH) : CW'(1);
         end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - CW'(1);
            r_a   <= r_a >> 1;
            r_bsh <= r_bsh << 1;
            r_acc <= w_acc_nxt;
         end
         if (w_finish) begin
            r_result <= w_res_nxt;
            r_error  <= w_err_nxt;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected completions, monitors pop on done.
// Covers add/sub/overflow, signed multiply, ignored starts, back-to-back, mid-op reset, WIDTH=8.
// Expected results and completion cycles are hand-computed constants.
module tb_seq_alu;

   typedef struct {
      logic [31:0] res;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   int          cyc;
   int          tests;
   int          fails;

   logic        start16, busy16, done16, error16;
   logic [3:0]  cmd16;
   logic [15:0] a16, b16;
   logic [31:0] result16;

   logic        start8, busy8, done8, error8;
   logic [3:0]  cmd8;
   logic [7:0]  a8, b8;
   logic [15:0] result8;

   exp_t q16[$];
   exp_t q8[$];

   seq_alu #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .command(cmd16),
      .inputA(a16), .inputB(b16), .busy(busy16), .done(done16),
      .result(result16), .error(error16)
   );

   seq_alu #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .command(cmd8),
      .inputA(a8), .inputB(b8), .busy(busy8), .done(done8),
      .result(result8), .error(error8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor for the 16-bit instance.
   always @(negedge clk) begin
      if (rst_n && done16) begin
         if (q16.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done16: done seen at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = q16.pop_front();
            chk("result16", result16, e.res);
            chk("error16", {31'd0, error16}, {31'd0, e.err});
            chk("done_cycle16", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (q8.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done8: done seen at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = q8.pop_front();
            chk("result8", {16'd0, result8}, e.res);
            chk("error8", {31'd0, error8}, {31'd0, e.err});
            chk("done_cycle8", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic issue16(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] er, input logic ee, input int lat,
                          input bit now, input bit push);
      if (!now) @(negedge clk);
      start16 = 1'b1;
      cmd16   = c;
      a16     = a;
      b16     = b;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      if (push) q16.push_back('{er, ee, cyc + lat});
   endtask

   task automatic issue8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] er, input logic ee, input int lat);
      @(negedge clk);
      start8 = 1'b1;
      cmd8   = c;
      a8     = a;
      b8     = b;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      q8.push_back('{{16'd0, er}, ee, cyc + lat});
   endtask

   task automatic wait_idle16();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy16) break;
      end
      chk("idle_timeout16", {31'd0, busy16}, 32'd0);
   endtask

   task automatic wait_idle8();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy8) break;
      end
      chk("idle_timeout8", {31'd0, busy8}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc     = 0;
      tests   = 0;
      fails   = 0;
      rst_n   = 1'b0;
      start16 = 1'b0; cmd16 = 4'd0; a16 = '0; b16 = '0;
      start8  = 1'b0; cmd8  = 4'd0; a8  = '0; b8  = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy16}, 32'd0);
      chk("rst_done", {31'd0, done16}, 32'd0);
      chk("rst_result", result16, 32'd0);
      chk("rst_error", {31'd0, error16}, 32'd0);
      rst_n = 1'b1;

      // Add / subtract / overflow.
      issue16(4'b0001, 16'd6,     16'd1,     32'h00000007, 1'b0, 1, 0, 1); wait_idle16();
      issue16(4'b0101, 16'd6,     16'd1,     32'h00000005, 1'b0, 1, 0, 1); wait_idle16();
      issue16(4'b0001, 16'h7FFF,  16'd1,     32'hFFFF8000, 1'b1, 1, 0, 1); wait_idle16();
      issue16(4'b0101, 16'h8000,  16'd1,     32'h00007FFF, 1'b1, 1, 0, 1); wait_idle16();
      issue16(4'b0001, 16'hFFFF,  16'hFFFF,  32'hFFFFFFFE, 1'b0, 1, 0, 1); wait_idle16();

      // Signed multiply.
      issue16(4'b0010, 16'd6,     16'd1,     32'h00000006, 1'b0, 16, 0, 1); wait_idle16();
      issue16(4'b0010, 16'hFFFD,  16'd5,     32'hFFFFFFF1, 1'b0, 16, 0, 1); wait_idle16();
      issue16(4'b0010, 16'h8000,  16'h8000,  32'h40000000, 1'b0, 16, 0, 1); wait_idle16();

      // Unsupported opcode.
      issue16(4'b0011, 16'd9,     16'd9,     32'h00000000, 1'b1, 1, 0, 1); wait_idle16();

      // Starts during a multiply are ignored.
      issue16(4'b0010, 16'd7,     16'hFFFE,  32'hFFFFFFF2, 1'b0, 16, 0, 1);
      repeat (2) @(negedge clk);
      start16 = 1'b1; cmd16 = 4'b0001; a16 = 16'd100; b16 = 16'd100;
      @(negedge clk);
      start16 = 1'b0;
      repeat (4) @(negedge clk);
      start16 = 1'b1; cmd16 = 4'b0010; a16 = 16'd3; b16 = 16'd3;
      @(negedge clk);
      start16 = 1'b0;
      wait_idle16();
      repeat (3) @(negedge clk);

      // Back-to-back: new add accepted in the done cycle.
      issue16(4'b0010, 16'd3,     16'd3,     32'h00000009, 1'b0, 16, 0, 1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done16) break;
      end
      chk("b2b_done_seen", {31'd0, done16}, 32'd1);
      issue16(4'b0001, 16'd2,     16'd3,     32'h00000005, 1'b0, 1, 1, 1); wait_idle16();

      // Mid-operation reset.
      issue16(4'b0001, 16'h7FFF,  16'd1,     32'hFFFF8000, 1'b1, 1, 0, 1); wait_idle16();
      issue16(4'b0010, 16'hFFFD,  16'd5,     32'h0,        1'b0, 16, 0, 0);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy16}, 32'd0);
      chk("midrst_done", {31'd0, done16}, 32'd0);
      chk("midrst_result", result16, 32'd0);
      chk("midrst_error", {31'd0, error16}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_result", result16, 32'd0);
      issue16(4'b0010, 16'hFFFD,  16'd5,     32'hFFFFFFF1, 1'b0, 16, 0, 1); wait_idle16();

      // WIDTH=8 instance.
      issue8(4'b0010, 8'h80, 8'h7F, 16'hC080, 1'b0, 8); wait_idle8();
      issue8(4'b0010, 8'h80, 8'h80, 16'h4000, 1'b0, 8); wait_idle8();
      issue8(4'b0101, 8'h80, 8'h01, 16'h007F, 1'b1, 1); wait_idle8();

      repeat (5) @(negedge clk);
      while (q16.size() > 0) begin
         exp_t e;
         e = q16.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_done16: no done for expected result %h at cycle %0d", e.res, e.cyc);
      end
      while (q8.size() > 0) begin
         exp_t e;
         e = q8.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_done8: no done for expected result %h at cycle %0d", e.res, e.cyc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Clocked, parametrised successor to the combinational add/sub/multiply datapath. It accepts one operation per start request and runs add and subtract in a single cycle. Signed multiply runs as an iterative shift-add over WIDTH cycles. Results, error flag and a one-cycle done pulse are registered and feed the command mux and seven-segment decode stage downstream.

## Interface
- WIDTH, 16, operand width in bits; result is 2*WIDTH bits; legal range 4..32.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low: assertion clears all state immediately; release is synchronous to clk.
- start  in  1  request; sampled only in IDLE.
- command  in  4  opcode: 4'b0001 add, 4'b0101 subtract, 4'b0010 signed multiply; all other codes are unsupported.
- inputA  in  WIDTH  operand A, two's complement.
- inputB  in  WIDTH  operand B, two's complement.
- busy  out  1  high while an operation is executing.
- done  out  1  one-cycle pulse when result and error update.
- result  out  2*WIDTH  registered result; holds until the next completion.
- error  out  1  registered; signed overflow for add/sub, or unsupported opcode.

## Operation
- States:
  - IDLE: wait for start.
  - EXEC: compute.
- No separate DONE state; done is registered alongside the return to IDLE.
- IDLE, start=1 at edge N:
  - latch inputA, inputB and command into internal registers;
  - go to EXEC with busy=1;
  - load the iteration counter with the operation latency: 1 for add, subtract and unsupported codes; WIDTH for multiply.
- Add/subtract:
  - compute sum = A + (B ^ {WIDTH{mode}}) + mode, with mode=1 for subtract;
  - result = the WIDTH-bit wrapped sum, sign-extended to 2*WIDTH (the upper WIDTH bits replicate bit WIDTH-1);
  - error = carry into MSB XOR carry out of MSB.
- Multiply:
  - signed radix-2 shift-add, one partial product per cycle, iterating i = 0..WIDTH-1;
  - iteration i adds B·A[i] aligned at bit i;
  - the final iteration, for the sign bit, subtracts instead of adds (two's-complement weight of A's MSB);
  - use a 2*WIDTH+1-bit accumulator internally; result is the exact 2*WIDTH-bit product;
  - error = 0 (the product always fits, including most-negative × most-negative = 2^(2*WIDTH-2)).
- Unsupported command: result = 0, error = 1.
- Completion, at the edge that ends the last EXEC cycle:
  - register result and error;
  - done = 1 for exactly one cycle;
  - busy = 0;
  - state = IDLE.
- start is ignored while busy=1. Operand and command changes during EXEC have no effect, since latched copies are used.
- A start arriving in the cycle where done=1 is accepted, giving back-to-back operation with no idle bubble.

## Timing
- Reset values: busy=0, done=0, result=0, error=0, state=IDLE, counter=0.
- Request accepted at edge N:
  - add/sub/unsupported: done=1 and result valid in the cycle after edge N+1;
  - multiply: done=1 and result valid in the cycle after edge N+WIDTH.
- busy is high from edge N until the completion edge; it is deasserted on the same edge that asserts done.
- Throughput: one operation per latency; no pipelining.
- rst_n asserted mid-operation:
  - outputs go to reset values asynchronously and the partial product is discarded;
  - no done pulse is generated;
  - the first start after release behaves as from cold reset.
- result and error are glitch-free registers. They change only on a completion edge or on reset.

## Test plan
- WIDTH=16, add: command=0001, A=6, B=1 → one cycle after start, result=32'h00000007, error=0, done high exactly one cycle.
- Subtract and overflow:
  - command=0101, A=6, B=1 → result=32'h00000005, error=0;
  - command=0001, A=16'h7FFF, B=1 → result=32'hFFFF8000, error=1.
- Multiply, each with done exactly 16 cycles after start and error=0:
  - A=6, B=1 → 32'h00000006;
  - A=-3, B=5 → 32'hFFFFFFF1;
  - A=B=16'h8000 → 32'h40000000.
- Handshake:
  - start multiply; assert start with new operands at cycles 3 and 8 → both ignored, single done, correct product;
  - start a new add in the done cycle → its done follows one cycle later.
- Reset: drop rst_n at cycle 7 of a multiply → busy, done, result and error go to 0 immediately with no done pulse; after release, A=-3, B=5 gives 32'hFFFFFFF1.
- Unsupported opcode and width:
  - command=0011 → result=0, error=1, done after 1 cycle;
  - WIDTH=8 instance: A=8'h80, B=8'h7F → result=16'hC080 after 8 cycles.
